// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared definitions for the rename/allocate controller: default sizes and FSM encoding.
package rename_alloc_ctrl_pkg;

  localparam int DEF_ROB_DEPTH      = 16;
  localparam int DEF_GPR_ADDR_WIDTH = 5;
  localparam int DEF_FLUSH_CYCLES   = 2;
  localparam int FLUSH_CNT_W        = 3;

  typedef enum logic {
    RENAME_RUN   = 1'b0,
    RENAME_FLUSH = 1'b1
  } rename_state_e;

endpackage

// File: rtl/rename_alloc_ctrl_rob_ptr_ctr.sv
// Wrapping ROB pointer with synchronous clear (priority) and increment.
module rob_ptr_ctr #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [TW-1:0] ptr
);

  // ROB depth is a power of two, so natural overflow gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + TW'(1);
  end

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename/allocate controller: ROB tag allocation, in-order retire, flush recovery sequencing.
module rename_alloc_ctrl
  import rename_alloc_ctrl_pkg::*;
#(
  parameter  int ROB_DEPTH      = DEF_ROB_DEPTH,
  parameter  int GPR_ADDR_WIDTH = DEF_GPR_ADDR_WIDTH,
  parameter  int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  localparam int TW             = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      disp_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] disp_dst_addr,
  input  logic                      disp_dst_wen,
  output logic                      disp_ready,
  output logic                      allocate_en,
  output logic [TW-1:0]             rob_alloc_tag_2rat,
  output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
  output logic                      rob_alloc_dst_wen_2rat,
  input  logic                      cmt_valid,
  output logic                      commit_en,
  output logic [TW-1:0]             cmt_tag,
  input  logic                      flush,
  output logic [TW:0]               rob_count,
  output logic                      rob_full,
  output logic                      rob_empty
);

  localparam logic [TW:0]            DEPTH_C  = (TW+1)'(ROB_DEPTH);
  localparam logic [FLUSH_CNT_W-1:0] RELOAD_C = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  rename_state_e          state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [TW:0]            count;
  logic [TW-1:0]          head, tail;
  logic                   alloc_fire;

  rob_ptr_ctr #(.TW(TW)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (commit_en),
    .ptr   (head)
  );

  rob_ptr_ctr #(.TW(TW)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (alloc_fire),
    .ptr   (tail)
  );

  // Ready depends only on registered state, never on a same-cycle commit.
  assign rob_full   = (count == DEPTH_C);
  assign rob_empty  = (count == '0);
  assign rob_count  = count;
  assign disp_ready = (state == RENAME_RUN) && !rob_full;
  assign alloc_fire = disp_valid && disp_ready && !flush;
  assign commit_en  = cmt_valid && !rob_empty && !flush && (state == RENAME_RUN);

  assign allocate_en             = alloc_fire;
  assign rob_alloc_tag_2rat      = tail;
  assign rob_alloc_dst_addr_2rat = disp_dst_addr;
  // x0 still takes a tag for ordering but never renames.
  assign rob_alloc_dst_wen_2rat  = disp_dst_wen && (disp_dst_addr != '0);
  assign cmt_tag                 = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (flush) count <= '0;
    else if (alloc_fire && !commit_en) count <= count + (TW+1)'(1);
    else if (!alloc_fire && commit_en) count <= count - (TW+1)'(1);
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (flush) begin
      state_nxt     = RENAME_FLUSH;
      flush_cnt_nxt = RELOAD_C;
    end else if (state == RENAME_FLUSH) begin
      if (flush_cnt == '0) state_nxt = RENAME_RUN;
      else                 flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RENAME_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

endmodule
